// File: rtl/eth_filter_pkg.sv
// Shared types and constants for the Ethernet destination-address filter.
package eth_filter_pkg;

  localparam int MAC_W = 48;
  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_REPLAY = 2'd1,
    ST_PASS   = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  // Index width for a table of n entries; a single-entry table still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_addr_table.sv
// Programmable unicast address table with a single-cycle parallel match.
module eth_addr_table
  import eth_filter_pkg::*;
#(
  parameter int              NUM_ADDR    = 4,
  parameter logic [MAC_W-1:0] DEFAULT_MAC = 48'hDEADBEEF1234,
  parameter int              IDX_W       = idx_w(NUM_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [MAC_W-1:0]  cfg_mac,
  input  logic              cfg_en,
  input  logic [MAC_W-1:0]  addr,
  output logic              hit
);

  logic [MAC_W-1:0]    mac_q [NUM_ADDR];
  logic [NUM_ADDR-1:0] en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ADDR; i++) begin
        mac_q[i] <= (i == 0) ? DEFAULT_MAC : '0;
      end
      en_q <= NUM_ADDR'(1);
    end else if (cfg_we && (32'(cfg_idx) < NUM_ADDR)) begin
      mac_q[cfg_idx] <= cfg_mac;
      en_q[cfg_idx]  <= cfg_en;
    end
  end

  // Reads the registered contents, so a write in the decision cycle is not yet visible.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_ADDR; i++) begin
      if (en_q[i] && (mac_q[i] == addr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/eth_addr_filter.sv
// Byte-stream destination-MAC filter: buffers the 6-byte header, decides, then replays or drops.
module eth_addr_filter
  import eth_filter_pkg::*;
#(
  parameter int              NUM_ADDR    = 4,
  parameter logic [MAC_W-1:0] DEFAULT_MAC = 48'hDEADBEEF1234,
  parameter int              CNT_W       = 32,
  parameter int              IDX_W       = idx_w(NUM_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [7:0]        in_tdata,
  input  logic              in_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [7:0]        out_tdata,
  output logic              out_tlast,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [MAC_W-1:0]  cfg_mac,
  input  logic              cfg_en,
  input  logic              cfg_promisc,
  input  logic              cfg_bcast_en,
  input  logic              cfg_mcast_en,
  output logic [CNT_W-1:0]  stat_accept,
  output logic [CNT_W-1:0]  stat_drop,
  output logic [CNT_W-1:0]  stat_runt,
  output logic [1:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where valid and ready are both high;
  // valid never waits on ready, and data/last stay stable while valid is high and ready is low.

  state_t           state_q, state_d;
  logic [2:0]       hdr_cnt_q;
  logic [2:0]       rp_q;
  logic             last_q;
  logic [7:0]       hdr_buf [6];
  logic [CNT_W-1:0] accept_q, drop_q, runt_q;

  logic [MAC_W-1:0] addr;
  logic             table_hit, is_bcast, is_group, match;
  logic             in_fire, out_fire, hdr_last;

  assign addr     = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], in_tdata};
  assign is_bcast = (addr == BCAST_MAC);
  assign is_group = addr[40];
  assign match    = cfg_promisc | (is_bcast & cfg_bcast_en) |
                    (is_group & ~is_bcast & cfg_mcast_en) | table_hit;
  assign hdr_last = (hdr_cnt_q == 3'd5);
  assign in_fire  = in_tvalid & in_tready;
  assign out_fire = out_tvalid & out_tready;

  assign stat_accept = accept_q;
  assign stat_drop   = drop_q;
  assign stat_runt   = runt_q;
  assign dbg_state   = state_q;

  eth_addr_table #(
    .NUM_ADDR    (NUM_ADDR),
    .DEFAULT_MAC (DEFAULT_MAC),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_mac (cfg_mac),
    .cfg_en  (cfg_en),
    .addr    (addr),
    .hit     (table_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = 8'h00;
    out_tlast  = 1'b0;
    case (state_q)
      ST_HDR: begin
        in_tready = rst_n;
        if (in_tvalid && hdr_last) begin
          if (match)         state_d = ST_REPLAY;
          else if (in_tlast) state_d = ST_HDR;
          else               state_d = ST_DROP;
        end
      end
      ST_REPLAY: begin
        out_tvalid = 1'b1;
        out_tdata  = hdr_buf[rp_q];
        out_tlast  = (rp_q == 3'd5) & last_q;
        if (out_tready && (rp_q == 3'd5)) state_d = last_q ? ST_HDR : ST_PASS;
      end
      ST_PASS: begin
        out_tvalid = in_tvalid;
        out_tdata  = in_tdata;
        out_tlast  = in_tlast;
        in_tready  = out_tready;
        if (in_tvalid && out_tready && in_tlast) state_d = ST_HDR;
      end
      ST_DROP: begin
        in_tready = rst_n;
        if (in_tvalid && in_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_q <= '0;
      rp_q      <= '0;
      last_q    <= 1'b0;
      accept_q  <= '0;
      drop_q    <= '0;
      runt_q    <= '0;
      for (int i = 0; i < 6; i++) hdr_buf[i] <= '0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (in_fire) begin
            hdr_buf[hdr_cnt_q] <= in_tdata;
            if (hdr_last) begin
              hdr_cnt_q <= '0;
              rp_q      <= '0;
              last_q    <= in_tlast;
              if (match) accept_q <= accept_q + CNT_W'(1);
              else       drop_q   <= drop_q + CNT_W'(1);
            end else if (in_tlast) begin
              hdr_cnt_q <= '0;
              runt_q    <= runt_q + CNT_W'(1);
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 3'd1;
            end
          end
        end
        ST_REPLAY: begin
          if (out_fire) rp_q <= (rp_q == 3'd5) ? 3'd0 : rp_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_addr_filter.sv
// Randomized bench for eth_addr_filter against a frame-level reference model.
module tb_eth_addr_filter;

  localparam logic [47:0] DEF_MAC = 48'hDEADBEEF1234;
  localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;

  logic        clk, rst_n;
  logic        in_tvalid, in_tready, in_tlast;
  logic [7:0]  in_tdata;
  logic        out_tvalid, out_tready, out_tlast;
  logic [7:0]  out_tdata;
  logic        cfg_we, cfg_en, cfg_promisc, cfg_bcast_en, cfg_mcast_en;
  logic [1:0]  cfg_idx;
  logic [47:0] cfg_mac;
  logic [31:0] stat_accept, stat_drop, stat_runt;
  logic [1:0]  dbg_state;

  eth_addr_filter #(.NUM_ADDR(4), .DEFAULT_MAC(DEF_MAC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mac(cfg_mac), .cfg_en(cfg_en),
    .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
    .stat_accept(stat_accept), .stat_drop(stat_drop), .stat_runt(stat_runt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [47:0] m_mac [4];
  bit          m_en  [4];
  int unsigned m_accept, m_drop, m_runt;
  logic [8:0]  exp_q [$];
  logic [7:0]  frm_q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mac[i] = (i == 0) ? DEF_MAC : 48'h0;
      m_en[i]  = (i == 0);
    end
    m_accept = 0; m_drop = 0; m_runt = 0;
    exp_q.delete();
  endtask

  function automatic bit model_match(input logic [47:0] d);
    bit hit;
    hit = cfg_promisc || (d == BCAST && cfg_bcast_en) || (d[40] && d != BCAST && cfg_mcast_en);
    for (int i = 0; i < 4; i++) if (m_en[i] && m_mac[i] == d) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_frame(input int n);
    logic [47:0] d;
    if (n < 6) begin
      m_runt++;
    end else begin
      d = {frm_q[0], frm_q[1], frm_q[2], frm_q[3], frm_q[4], frm_q[5]};
      if (model_match(d)) begin
        m_accept++;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, frm_q[i]});
      end else begin
        m_drop++;
      end
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  int   rdy_mode = 0;
  bit   gap_en   = 0;
  bit   held_v   = 0;
  logic [8:0] held;

  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ~out_tready;
        default: out_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_tvalid) begin
        if (held_v) check("stall_hold", {out_tlast, out_tdata}, held);
        if (out_tready) begin
          held_v = 0;
          check("out_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_byte", {out_tlast, out_tdata}, e);
          end
        end else begin
          held_v = 1;
          held   = {out_tlast, out_tdata};
        end
      end else begin
        held_v = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_frame(input logic [47:0] d, input int len);
    frm_q.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) frm_q.push_back(d[47 - 8*i -: 8]);
      else       frm_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic send_frame(input int stop_after, input bit chk_rdy);
    int n, waited;
    bit ok;
    n = frm_q.size();
    model_frame(n);
    for (int i = 0; i < n && i < stop_after; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      in_tvalid = 1'b1;
      in_tdata  = frm_q[i];
      in_tlast  = (i == n - 1);
      ok = 0; waited = 0;
      while (!ok && waited < 300) begin
        @(negedge clk);
        ok = in_tready;
        if (!ok) waited++;
      end
      if (!ok) begin
        check("in_tready_timeout", ok, 1);
        in_tvalid = 1'b0;
        return;
      end
      if (chk_rdy) check("in_tready_no_stall", waited, 0);
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [47:0] mac, input bit en);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_mac = mac; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_mac[idx] = mac;
    m_en[idx]  = en;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_accept"}, stat_accept, m_accept);
    check({tag, "_drop"},   stat_drop,   m_drop);
    check({tag, "_runt"},   stat_runt,   m_runt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] d;
    int          sel;
    rst_n = 1'b0;
    in_tvalid = 1'b0; in_tdata = 8'h00; in_tlast = 1'b0;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_mac = 48'h0; cfg_en = 1'b0;
    cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_in_tready",  in_tready,  0);
    check("rst_state",      dbg_state,  0);
    check_stats("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_tready", in_tready, 1);

    // Default entry, long frame
    build_frame(DEF_MAC, 64); send_frame(1 << 30, 0); drain(); check_stats("default64");

    // Unknown unicast dropped, then promiscuous
    build_frame(48'h001122334455, 20); send_frame(1 << 30, 1); drain(); check_stats("drop20");
    cfg_promisc = 1'b1;
    build_frame(48'h001122334455, 20); send_frame(1 << 30, 0); drain();
    cfg_promisc = 1'b0;
    check_stats("promisc20");

    // Broadcast / multicast
    build_frame(BCAST, 16); send_frame(1 << 30, 0); drain();
    cfg_bcast_en = 1'b1;
    build_frame(BCAST, 16); send_frame(1 << 30, 0); drain();
    cfg_mcast_en = 1'b1;
    build_frame(48'h01005E000001, 12); send_frame(1 << 30, 0); drain();
    check_stats("bcast_mcast");

    // Runt and exactly-header frames
    build_frame(DEF_MAC, 4); send_frame(1 << 30, 0); drain();
    build_frame(DEF_MAC, 6); send_frame(1 << 30, 0); drain();
    check_stats("runt_six");

    // Programmed entry with stalling sink
    cfg_write(3, 48'h020000000003, 1'b1);
    rdy_mode = 1;
    build_frame(48'h020000000003, 30); send_frame(1 << 30, 0); drain();
    rdy_mode = 0;
    check_stats("entry3_stall");

    // Reset in the middle of a passing frame
    build_frame(DEF_MAC, 40); send_frame(10, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_out_tvalid", out_tvalid, 0);
    check("midrst_out_tdata",  out_tdata,  0);
    check("midrst_out_tlast",  out_tlast,  0);
    check("midrst_in_tready",  in_tready,  0);
    model_reset();
    check_stats("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_frame(DEF_MAC, 12); send_frame(1 << 30, 0); drain(); check_stats("after_rst");

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      if (f % 5 == 0) begin
        cfg_promisc  = ($urandom_range(0, 7) == 0);
        cfg_bcast_en = 1'($urandom_range(0, 1));
        cfg_mcast_en = 1'($urandom_range(0, 1));
        rdy_mode     = $urandom_range(0, 2);
        gap_en       = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1)
          cfg_write($urandom_range(0, 3),
                    {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'($urandom_range(0, 3))},
                    1'($urandom_range(0, 1)));
      end
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = m_mac[$urandom_range(0, 3)];
        1:       d = {16'($urandom_range(0, 65535)), 32'($urandom)};
        2:       d = BCAST;
        default: d = {24'h01005E, 24'($urandom_range(0, 255))};
      endcase
      build_frame(d, $urandom_range(1, 24));
      send_frame(1 << 30, 0);
    end
    drain();
    rdy_mode = 0;
    check_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_addr_filter.md
ETH_ADDR_FILTER -- requirements
Module: eth_addr_filter

Interface
REQ-001 Parameter NUM_ADDR, default 4, number of programmable unicast destination-address entries (1..16).
REQ-002 Parameter DEFAULT_MAC, default 48'hDEADBEEF1234, reset contents of entry 0.
REQ-003 Parameter CNT_W, default 32, width of each statistics counter.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_tvalid / in_tready / in_tdata / in_tlast  in/out/in/in  1/1/8/1  AXI-Stream byte input; frame begins with 6-byte destination MAC, MSB byte first.
REQ-007 out_tvalid / out_tready / out_tdata / out_tlast  out/in/out/out  1/1/8/1  AXI-Stream byte output, accepted frames only.
REQ-008 cfg_we, cfg_idx, cfg_mac, cfg_en  input  1, IDX_W, 48, 1  table write: entry cfg_idx gets address cfg_mac and enable cfg_en.
REQ-009 cfg_promisc, cfg_bcast_en, cfg_mcast_en  input  1 each  accept-all, accept FF:FF:FF:FF:FF:FF, accept group bit (first byte bit 0) set.
REQ-010 stat_accept, stat_drop, stat_runt  output  CNT_W each  frame counters.

Function
REQ-011 FSM states: HDR, REPLAY, PASS, DROP; reset state HDR.
REQ-012 HDR: in_tready=1, out_tvalid=0; each accepted byte stored in 6-entry header buffer at index hdr_cnt (0..5), hdr_cnt increments.
REQ-013 HDR, in_tlast accepted with hdr_cnt<5: runt frame; stat_runt increments, hdr_cnt clears, remain HDR, nothing output.
REQ-014 HDR, 6th byte accepted: match evaluated on full 48-bit address including that byte; next state REPLAY if match else DROP (if 6th byte carries tlast and no match: stat_drop increments, next state HDR).
REQ-015 Match = cfg_promisc OR (bcast AND cfg_bcast_en) OR (group bit AND NOT bcast AND cfg_mcast_en) OR any enabled entry equal to address.
REQ-016 Decision uses table contents before any cfg_we in the same cycle.
REQ-017 REPLAY: in_tready=0; out_tvalid=1; out_tdata=buffer[rp]; rp advances 0..5 on each out_tready; out_tlast=0 except byte 5 carries stored tlast of 6th byte.
REQ-018 REPLAY byte 5 handshake: next state PASS, or HDR if stored tlast=1.
REQ-019 PASS: combinational pass-through: out_tvalid=in_tvalid, out_tdata=in_tdata, out_tlast=in_tlast, in_tready=out_tready; transfer with tlast returns to HDR.
REQ-020 DROP: in_tready=1, out_tvalid=0; accepted byte with tlast returns to HDR.
REQ-021 stat_accept increments once per frame on entering REPLAY; stat_drop once per frame on decision to drop; all counters wrap modulo 2^CNT_W.
REQ-022 Output data/last shall be held stable while out_tvalid=1 and out_tready=0.
REQ-023 Latency: first output byte valid the cycle after 6th input byte accepted; frame byte order preserved.
REQ-024 cfg writes take effect next cycle; cfg_idx >= NUM_ADDR ignored.
REQ-025 Back-to-back frames: byte after tlast in HDR-return cycle is first byte of new frame, no bubble required.

Reset
REQ-026 rst_n low: state HDR, hdr_cnt=0, rp=0, all counters 0, out_tvalid=0, out_tdata=0, out_tlast=0, in_tready reflects HDR (1) only after rst_n deasserts.
REQ-027 Reset contents: entry 0 = DEFAULT_MAC enabled; entries 1..NUM_ADDR-1 = 0 disabled.
REQ-028 Reset mid-frame discards partial frame; next byte after release treated as first byte of a frame.

Structure
REQ-029 Shared package eth_filter_pkg holds state enum, BCAST_MAC constant, MAC_W=48, and IDX_W=$clog2(NUM_ADDR) helper.
REQ-030 Sub-module eth_addr_table: register table, config write port, and single-cycle parallel match output; FSM and counters in top.

Verification
REQ-031 Frame dst DE:AD:BE:EF:12:34, 64 bytes, out_tready=1 -> identical 64 bytes out, tlast on byte 64, stat_accept=1.
REQ-032 Frame dst 00:11:22:33:44:55, 20 bytes -> no output, in_tready=1 throughout, stat_drop=1; then set cfg_promisc=1, same frame -> 20 bytes out.
REQ-033 Broadcast frame with cfg_bcast_en=0 -> dropped; with 1 -> forwarded; multicast 01:00:5E:00:00:01 with cfg_mcast_en=1 -> forwarded.
REQ-034 4-byte frame with tlast -> stat_runt=1, no output; exactly-6-byte matching frame -> 6 bytes out, tlast on 6th.
REQ-035 Program entry 3 = 02:00:00:00:00:03 enabled, send matching frame with out_tready toggling 1/0 every cycle -> all bytes out in order, stable during stalls, stat_accept increments.
REQ-036 Assert rst_n low mid-PASS after 10 of 40 bytes -> outputs 0, counters 0; next frame processed normally.
